// File: rtl/core_seq_if.sv
// Bus bundle between the sequencer core and its fetch, data-memory and
// datapath neighbours. The core connects through the master modport.
interface core_seq_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 32
);
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_ack;
    logic [31:0]      imem_rdata;
    logic [31:0]      ir;
    logic [PC_W-1:0]  pc;
    logic             br_taken;
    logic [PC_W-1:0]  br_off;
    logic             ex_en;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ack;
    logic             rf_we;
    logic             mem_to_reg;
    logic             halted;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instret;

    modport master (
        output imem_req, imem_addr, ir, pc, ex_en, dmem_req, dmem_we,
               rf_we, mem_to_reg, halted, trap_cause, instret,
        input  imem_ack, imem_rdata, br_taken, br_off, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, ir, pc, ex_en, dmem_req, dmem_we,
               rf_we, mem_to_reg, halted, trap_cause, instret,
        output imem_ack, imem_rdata, br_taken, br_off, dmem_ack
    );
endinterface

// File: rtl/core_seq.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with trap-to-HALT.
// All strobes and requests are registered, so they depend on state only.
module core_seq #(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic       clk,
    input  logic       rst,
    core_seq_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [1:0] {
        C_ALU, C_LOAD, C_STORE, C_BRANCH
    } cls_t;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_ALIGN   = 2'd2;

    state_t           r_state;
    cls_t             r_cls;
    logic [PC_W-1:0]  r_pc;
    logic [31:0]      r_ir;
    logic [CNT_W-1:0] r_instret;
    logic             r_halted;
    logic [1:0]       r_trap;
    logic             r_imem_req;
    logic             r_ex_en;
    logic             r_dmem_req;
    logic             r_dmem_we;
    logic             r_rf_we;
    logic             r_mem_to_reg;

    logic [PC_W-1:0]  w_pc_plus4;
    logic [PC_W-1:0]  w_br_target;
    logic [2:0]       w_dec;

    // {legal, class}
    function automatic logic [2:0] classify(input logic [6:0] opc);
        case (opc)
            7'b0110011, 7'b0010011: classify = {1'b1, C_ALU};
            7'b0000011:             classify = {1'b1, C_LOAD};
            7'b0100011:             classify = {1'b1, C_STORE};
            7'b1100011:             classify = {1'b1, C_BRANCH};
            default:                classify = {1'b0, C_ALU};
        endcase
    endfunction

    // Unsigned PC_W-bit add: a sign-extended negative offset wraps correctly.
    assign w_pc_plus4  = r_pc + PC_W'(4);
    assign w_br_target = bus.br_taken ? (r_pc + bus.br_off) : w_pc_plus4;
    assign w_dec       = classify(r_ir[6:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_cls        <= C_ALU;
            r_pc         <= RESET_PC;
            r_ir         <= '0;
            r_instret    <= '0;
            r_halted     <= 1'b0;
            r_trap       <= TRAP_NONE;
            r_imem_req   <= 1'b1;
            r_ex_en      <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_rf_we      <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else begin
            r_imem_req   <= 1'b0;
            r_ex_en      <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_rf_we      <= 1'b0;
            r_mem_to_reg <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        r_ir    <= bus.imem_rdata;
                        r_state <= S_DECODE;
                    end else begin
                        r_imem_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (w_dec[2]) begin
                        r_cls   <= cls_t'(w_dec[1:0]);
                        r_state <= S_EXEC;
                        r_ex_en <= 1'b1;
                    end else begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        r_trap   <= TRAP_ILLEGAL;
                    end
                end
                S_EXEC: begin
                    case (r_cls)
                        C_LOAD, C_STORE: begin
                            r_state    <= S_MEM;
                            r_dmem_req <= 1'b1;
                            r_dmem_we  <= (r_cls == C_STORE);
                        end
                        C_BRANCH: begin
                            if (w_br_target[1:0] != 2'b00) begin
                                r_state  <= S_HALT;
                                r_halted <= 1'b1;
                                r_trap   <= TRAP_ALIGN;
                            end else begin
                                r_pc       <= w_br_target;
                                r_instret  <= r_instret + 1'b1;
                                r_state    <= S_FETCH;
                                r_imem_req <= 1'b1;
                            end
                        end
                        default: begin
                            r_state <= S_WB;
                            r_rf_we <= 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (!bus.dmem_ack) begin
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= (r_cls == C_STORE);
                    end else if (r_cls == C_LOAD) begin
                        r_state      <= S_WB;
                        r_rf_we      <= 1'b1;
                        r_mem_to_reg <= 1'b1;
                    end else begin
                        r_pc       <= w_pc_plus4;
                        r_instret  <= r_instret + 1'b1;
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                S_WB: begin
                    r_pc       <= w_pc_plus4;
                    r_instret  <= r_instret + 1'b1;
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    assign bus.imem_req   = r_imem_req;
    assign bus.imem_addr  = r_pc;
    assign bus.ir         = r_ir;
    assign bus.pc         = r_pc;
    assign bus.ex_en      = r_ex_en;
    assign bus.dmem_req   = r_dmem_req;
    assign bus.dmem_we    = r_dmem_we;
    assign bus.rf_we      = r_rf_we;
    assign bus.mem_to_reg = r_mem_to_reg;
    assign bus.halted     = r_halted;
    assign bus.trap_cause = r_trap;
    assign bus.instret    = r_instret;
endmodule
